// File: rtl/sig_acq_pkg.sv
// Shared constants for the TX FIFO arbiter: almost-full threshold and FSM state encodings.
package sig_acq_pkg;

  localparam logic [11:0] AFULL_LEVEL_DEF = 12'd2000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/tx_fifo_arb_frame_cnt16.sv
// 16-bit wrapping count of completed frames for one source.
module frame_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 16'd0;
    end else if (inc) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/tx_fifo_arb.sv
// Two-source frame arbiter feeding a UART TX FIFO; whole frames are granted round-robin
// and bytes are written one cycle after they are accepted.
module tx_fifo_arb
  import sig_acq_pkg::*;
#(
  parameter logic [11:0] AFULL_LEVEL = AFULL_LEVEL_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        src0_valid,
  input  logic [7:0]  src0_data,
  input  logic        src0_last,
  output logic        src0_ready,
  input  logic        src1_valid,
  input  logic [7:0]  src1_data,
  input  logic        src1_last,
  output logic        src1_ready,
  output logic        tx_fifo_wen,
  output logic [7:0]  tx_fifo_wdata,
  input  logic        tx_fifo_full,
  input  logic [11:0] tx_fifo_usedw,
  output logic [15:0] frame_cnt0,
  output logic [15:0] frame_cnt1,
  output logic        busy
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       last_src;
  logic       afull;
  logic       xfer0;
  logic       xfer1;
  logic       done0;
  logic       done1;

  assign afull      = tx_fifo_full | (tx_fifo_usedw >= AFULL_LEVEL);
  assign src0_ready = (state == GNT0) & ~afull;
  assign src1_ready = (state == GNT1) & ~afull;
  assign xfer0      = src0_valid & src0_ready;
  assign xfer1      = src1_valid & src1_ready;
  assign done0      = xfer0 & src0_last;
  assign done1      = xfer1 & src1_last;
  assign busy       = (state != IDLE);

  // Under contention the source that did not finish the previous frame wins.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ena) begin
          if (src0_valid && src1_valid) begin
            state_nxt = last_src ? GNT0 : GNT1;
          end else if (src0_valid) begin
            state_nxt = GNT0;
          end else if (src1_valid) begin
            state_nxt = GNT1;
          end
        end
      end
      GNT0: begin
        if (done0) begin
          state_nxt = IDLE;
        end
      end
      GNT1: begin
        if (done1) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_src <= 1'b1;
    end else begin
      state <= state_nxt;
      if (done0) begin
        last_src <= 1'b0;
      end else if (done1) begin
        last_src <= 1'b1;
      end
    end
  end

  // Write data holds its last value when no byte is transferred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_fifo_wen   <= 1'b0;
      tx_fifo_wdata <= 8'd0;
    end else begin
      tx_fifo_wen <= xfer0 | xfer1;
      if (xfer0) begin
        tx_fifo_wdata <= src0_data;
      end else if (xfer1) begin
        tx_fifo_wdata <= src1_data;
      end
    end
  end

  frame_cnt16 u_cnt0 (
    .clk   (clk),
    .rst   (rst),
    .inc   (done0),
    .count (frame_cnt0)
  );

  frame_cnt16 u_cnt1 (
    .clk   (clk),
    .rst   (rst),
    .inc   (done1),
    .count (frame_cnt1)
  );

endmodule

// File: tb/tb_tx_fifo_arb.sv
// Randomised bench for tx_fifo_arb checked against a frame-level ownership model.
module tb_tx_fifo_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [1:0]  sv;
  logic [1:0]  sl;
  logic [7:0]  sd [2];
  logic        rdy0;
  logic        rdy1;
  logic        wen;
  logic [7:0]  wdata;
  logic        full;
  logic [11:0] usedw;
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic        busy;

  int tests = 0;
  int failures = 0;

  // Reference model: who owns the FIFO, who finished last, and what should appear on the write port.
  int          owner;
  int          last_src_m;
  logic [15:0] cnt_m [2];
  logic        exp_wen;
  logic [7:0]  exp_wdata;

  // Source generators and environment knobs.
  int          idx [2];
  int          len [2];
  int          frames_left [2];
  int          len_min;
  int          len_max;
  int          valid_pct;
  bit          rand_fifo;
  logic [11:0] usedw_set;
  logic        full_set;
  int          wen_count;
  int          done_order [$];

  always #5 clk = ~clk;

  tx_fifo_arb dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .src0_valid    (sv[0]),
    .src0_data     (sd[0]),
    .src0_last     (sl[0]),
    .src0_ready    (rdy0),
    .src1_valid    (sv[1]),
    .src1_data     (sd[1]),
    .src1_last     (sl[1]),
    .src1_ready    (rdy1),
    .tx_fifo_wen   (wen),
    .tx_fifo_wdata (wdata),
    .tx_fifo_full  (full),
    .tx_fifo_usedw (usedw),
    .frame_cnt0    (cnt0),
    .frame_cnt1    (cnt1),
    .busy          (busy)
  );

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    owner      = -1;
    last_src_m = 1;
    cnt_m[0]   = 16'd0;
    cnt_m[1]   = 16'd0;
    exp_wen    = 1'b0;
    exp_wdata  = 8'd0;
    idx[0]     = 0;
    idx[1]     = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_rdy0"}, rdy0, 0);
    check_output({tag, "_rdy1"}, rdy1, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_wen"}, wen, 0);
    check_output({tag, "_wdata"}, wdata, 0);
    check_output({tag, "_cnt0"}, cnt0, 0);
    check_output({tag, "_cnt1"}, cnt1, 0);
  endtask

  function automatic int new_len();
    return $urandom_range(len_max, len_min);
  endfunction

  // One clock cycle: drive at negedge, check readies, then check the write port after the edge.
  task automatic apply_stimulus();
    logic       xfer;
    logic       done;
    logic [7:0] xd;
    logic       xl;
    logic       afull_m;
    logic [1:0] fire;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sv[s] = (frames_left[s] > 0) && ($urandom_range(99) < valid_pct);
      sd[s] = 8'(s * 128 + idx[s]);
      sl[s] = (idx[s] == len[s] - 1);
    end
    if (rand_fifo) begin
      full = ($urandom_range(19) == 0);
      case ($urandom_range(3))
        0: usedw = 12'd0;
        1: usedw = 12'd1999;
        2: usedw = 12'd2000;
        default: usedw = 12'(($urandom_range(1) == 0) ? 4095 : $urandom_range(1998));
      endcase
    end else begin
      full  = full_set;
      usedw = usedw_set;
    end
    #1;
    afull_m = full || (usedw >= 12'd2000);
    check_output("ready0", rdy0, (owner == 0) && !afull_m);
    check_output("ready1", rdy1, (owner == 1) && !afull_m);
    check_output("busy", busy, owner != -1);
    fire = {sv[1] & rdy1, sv[0] & rdy0};
    xfer = 1'b0;
    xd   = 8'd0;
    xl   = 1'b0;
    if (owner >= 0 && !afull_m && sv[owner]) begin
      xfer = 1'b1;
      xd   = sd[owner];
      xl   = sl[owner];
    end
    @(posedge clk);
    #1;
    done    = xfer && xl;
    exp_wen = xfer;
    if (xfer) exp_wdata = xd;
    if (done) begin
      cnt_m[owner] = cnt_m[owner] + 16'd1;
      last_src_m   = owner;
      owner        = -1;
    end else if (owner == -1 && ena) begin
      if (sv[0] && sv[1]) owner = (last_src_m == 0) ? 1 : 0;
      else if (sv[0]) owner = 0;
      else if (sv[1]) owner = 1;
    end
    check_output("wen", wen, exp_wen);
    check_output("wdata", wdata, exp_wdata);
    check_output("frame_cnt0", cnt0, cnt_m[0]);
    check_output("frame_cnt1", cnt1, cnt_m[1]);
    if (wen) wen_count++;
    for (int s = 0; s < 2; s++) begin
      if (fire[s]) begin
        if (sl[s]) begin
          done_order.push_back(s);
          idx[s] = 0;
          frames_left[s]--;
          len[s] = new_len();
        end else begin
          idx[s]++;
        end
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus();
  endtask

  task automatic run_frames(input string tag, input int budget);
    int n = 0;
    while ((frames_left[0] > 0 || frames_left[1] > 0) && n < budget) begin
      apply_stimulus();
      n++;
    end
    if (frames_left[0] > 0 || frames_left[1] > 0)
      check_output({tag, "_timeout"}, n, 0);
  endtask

  task automatic set_frames(input int f0, input int f1, input int lmin, input int lmax);
    len_min        = lmin;
    len_max        = lmax;
    frames_left[0] = f0;
    frames_left[1] = f1;
    len[0]         = new_len();
    len[1]         = new_len();
    idx[0]         = 0;
    idx[1]         = 0;
  endtask

  // Asynchronous reset pulse landing in the middle of a cycle.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_values({tag, "_async"});
    @(posedge clk);
    #1;
    check_reset_values({tag, "_held"});
    sv = 2'b00;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    ena       = 1'b1;
    sv        = 2'b00;
    sl        = 2'b00;
    sd[0]     = 8'd0;
    sd[1]     = 8'd0;
    full      = 1'b0;
    usedw     = 12'd0;
    full_set  = 1'b0;
    usedw_set = 12'd0;
    rand_fifo = 1'b0;
    valid_pct = 100;
    wen_count = 0;
    frames_left[0] = 0;
    frames_left[1] = 0;
    len[0] = 1;
    len[1] = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;

    // Single 72-byte frame from src0.
    wen_count = 0;
    set_frames(1, 0, 72, 72);
    run_frames("frame72", 400);
    run_cycles(2);
    check_output("frame72_wen_pulses", wen_count, 72);
    check_output("frame72_cnt0", cnt0, 1);

    // Contention right after reset: src0 first, then src1.
    pulse_reset("rst_b");
    done_order.delete();
    set_frames(1, 1, 6, 6);
    run_frames("contend", 200);
    check_output("contend_cnt0", cnt0, 1);
    check_output("contend_cnt1", cnt1, 1);
    check_output("contend_first", (done_order.size() > 0) ? done_order[0] : 9, 0);

    // Round-robin over three contended frames.
    pulse_reset("rst_c");
    done_order.delete();
    set_frames(2, 1, 4, 4);
    run_frames("rr", 200);
    check_output("rr_count", done_order.size(), 3);
    if (done_order.size() == 3) begin
      check_output("rr_order0", done_order[0], 0);
      check_output("rr_order1", done_order[1], 1);
      check_output("rr_order2", done_order[2], 0);
    end

    // Almost-full threshold mid-frame.
    set_frames(1, 0, 20, 20);
    usedw_set = 12'd1999;
    run_cycles(6);
    usedw_set = 12'd2000;
    run_cycles(3);
    usedw_set = 12'd1999;
    run_frames("afull", 200);
    usedw_set = 12'd0;

    // Reset at byte 10 of a src1 frame, then a clean frame.
    pulse_reset("rst_e");
    set_frames(0, 1, 20, 20);
    for (int i = 0; i < 100 && idx[1] != 10; i++) apply_stimulus();
    check_output("midframe_reached", idx[1], 10);
    pulse_reset("rst_mid");
    check_output("midframe_cnt1", cnt1, 0);
    set_frames(0, 1, 20, 20);
    run_frames("after_rst", 200);
    check_output("after_rst_cnt1", cnt1, 1);

    // Randomised traffic with random FIFO back-pressure.
    rand_fifo = 1'b1;
    valid_pct = 70;
    set_frames(30, 30, 1, 8);
    run_frames("random", 6000);
    rand_fifo = 1'b0;
    valid_pct = 100;
    run_cycles(2);

    // Counter wrap from 16'hFFFF.
    force dut.u_cnt0.count = 16'hFFFF;
    #1;
    release dut.u_cnt0.count;
    cnt_m[0] = 16'hFFFF;
    check_output("preload_cnt0", cnt0, 16'hFFFF);
    set_frames(1, 0, 1, 1);
    run_frames("wrap", 50);
    check_output("wrap_cnt0", cnt0, 0);

    // No grants while disabled, then traffic resumes.
    ena = 1'b0;
    set_frames(1, 1, 3, 3);
    run_cycles(6);
    check_output("ena_off_left0", frames_left[0], 1);
    check_output("ena_off_left1", frames_left[1], 1);
    ena = 1'b1;
    run_frames("ena_on", 100);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
